// File: rtl/osc_trigger_capture_if.sv
// rtl/osc_trigger_capture_if.sv - ADC sample stream and FIFO write port bundle
//
// Purpose: groups the incoming ADC sample stream and the outgoing FIFO write
// port of the trigger/capture stage.
// Signals:
//   adc_data   ADC sample, unsigned
//   adc_valid  adc_data valid this cycle
//   fifo_full  FIFO is full
//   fifo_in    sample written to the FIFO
//   fifo_push  FIFO push strobe
// Modports:
//   master  the capture stage (consumes samples, drives the FIFO write port)
//   slave   the surroundings (ADC source plus FIFO)
interface osc_trigger_capture_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] adc_data;
    logic             adc_valid;
    logic             fifo_full;
    logic [WIDTH-1:0] fifo_in;
    logic             fifo_push;

    modport master (
        input  adc_data,
        input  adc_valid,
        input  fifo_full,
        output fifo_in,
        output fifo_push
    );

    modport slave (
        output adc_data,
        output adc_valid,
        output fifo_full,
        input  fifo_in,
        input  fifo_push
    );
endinterface

// File: rtl/osc_trigger_capture.sv
// rtl/osc_trigger_capture.sv - oscilloscope trigger detector and record capture into the sample FIFO
//
// Purpose: watches the ADC sample stream, detects a level/slope trigger (or an
// auto-mode timeout), then pushes exactly RECORD_LEN consecutive samples into the
// FIFO. One capture per arm.
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   bus         master side of osc_trigger_capture_if (ADC stream in, FIFO write out)
//   arm         start a capture (pulse)
//   abort       cancel and return to idle (pulse), wins over arm
//   trig_level  trigger threshold, unsigned
//   trig_slope  0 = rising, 1 = falling
//   trig_auto   1 = timeout forces a trigger
//   busy        armed or capturing
//   triggered   one-cycle pulse, coincident with the push of the trigger sample
//   forced      sticky: last trigger came from the auto timeout
//   done        record complete
//   overflow    sticky: at least one record sample dropped because the FIFO was full
module osc_trigger_capture #(
    parameter int WIDTH      = 8,
    parameter int BASE       = 9,
    parameter int RECORD_LEN = 2**BASE,
    parameter int AUTO_TMO   = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    osc_trigger_capture_if.master bus,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     trig_level,
    input  logic                 trig_slope,
    input  logic                 trig_auto,
    output logic                 busy,
    output logic                 triggered,
    output logic                 forced,
    output logic                 done,
    output logic                 overflow
);

    localparam int TMO_W = $clog2(AUTO_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(AUTO_TMO);
    localparam logic [BASE:0]    REC_LAST = (BASE + 1)'(RECORD_LEN);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [BASE:0]    smp_cnt_q, smp_cnt_d;
    logic [WIDTH-1:0] fifo_in_q, fifo_in_d;
    logic             fifo_push_q, fifo_push_d;
    logic             busy_q, busy_d;
    logic             triggered_q, triggered_d;
    logic             forced_q, forced_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;

    logic [TMO_W-1:0] tmo_next;
    logic [BASE:0]    smp_next;
    logic             rise_hit;
    logic             fall_hit;
    logic             slope_hit;
    logic             tmo_hit;
    logic             take;

    // The timeout counter saturates so that enabling auto mode late (after
    // the threshold was already passed) still forces a trigger on the next sample.
    assign tmo_next = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
    assign smp_next = smp_cnt_q + (BASE + 1)'(1);

    assign rise_hit  = (prev_q < trig_level) && (bus.adc_data >= trig_level);
    assign fall_hit  = (prev_q > trig_level) && (bus.adc_data <= trig_level);
    // Neither source may fire on the first sample after arming: it only seeds prev.
    assign slope_hit = prev_valid_q && (trig_slope ? fall_hit : rise_hit);
    assign tmo_hit   = prev_valid_q && trig_auto && (tmo_next == TMO_MAX);

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        tmo_cnt_d    = tmo_cnt_q;
        smp_cnt_d    = smp_cnt_q;
        fifo_in_d    = fifo_in_q;
        fifo_push_d  = 1'b0;
        triggered_d  = 1'b0;
        forced_d     = forced_q;
        overflow_d   = overflow_q;
        take         = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    // A sample coinciding with arm is deliberately not looked at.
                    if (arm) begin
                        state_d      = S_ARMED;
                        forced_d     = 1'b0;
                        overflow_d   = 1'b0;
                        tmo_cnt_d    = '0;
                        smp_cnt_d    = '0;
                        prev_valid_d = 1'b0;
                    end
                end
                S_ARMED: begin
                    if (bus.adc_valid) begin
                        tmo_cnt_d    = tmo_next;
                        prev_d       = bus.adc_data;
                        prev_valid_d = 1'b1;
                        if (slope_hit || tmo_hit) begin
                            state_d     = S_CAPTURE;
                            triggered_d = 1'b1;
                            // A genuine slope match on the timeout sample is not "forced".
                            forced_d    = !slope_hit;
                            take        = 1'b1;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (bus.adc_valid) begin
                        take = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // Every record sample advances the count, pushed or dropped, so the
            // record always spans a fixed number of ADC samples.
            if (take) begin
                smp_cnt_d = smp_next;
                if (bus.fifo_full) begin
                    overflow_d = 1'b1;
                end else begin
                    fifo_push_d = 1'b1;
                    fifo_in_d   = bus.adc_data;
                end
                if (smp_next == REC_LAST) begin
                    state_d = S_DONE;
                end
            end
        end

        busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            tmo_cnt_q    <= '0;
            smp_cnt_q    <= '0;
            fifo_in_q    <= '0;
            fifo_push_q  <= 1'b0;
            busy_q       <= 1'b0;
            triggered_q  <= 1'b0;
            forced_q     <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            tmo_cnt_q    <= tmo_cnt_d;
            smp_cnt_q    <= smp_cnt_d;
            fifo_in_q    <= fifo_in_d;
            fifo_push_q  <= fifo_push_d;
            busy_q       <= busy_d;
            triggered_q  <= triggered_d;
            forced_q     <= forced_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.fifo_in   = fifo_in_q;
    assign bus.fifo_push = fifo_push_q;
    assign busy          = busy_q;
    assign triggered     = triggered_q;
    assign forced        = forced_q;
    assign done          = done_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_osc_trigger_capture.sv
// tb/tb_osc_trigger_capture.sv - self-checking bench for osc_trigger_capture with a behavioural model
module tb_osc_trigger_capture;

    localparam int REC = 512;
    localparam int TMO = 16;

    logic       clk;
    logic       rst_n;
    logic       arm;
    logic       abort;
    logic [7:0] trig_level;
    logic       trig_slope;
    logic       trig_auto;
    logic       busy;
    logic       triggered;
    logic       forced;
    logic       done;
    logic       overflow;

    osc_trigger_capture_if #(.WIDTH(8)) bus ();

    osc_trigger_capture #(
        .WIDTH(8),
        .BASE(9),
        .AUTO_TMO(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .arm(arm),
        .abort(abort),
        .trig_level(trig_level),
        .trig_slope(trig_slope),
        .trig_auto(trig_auto),
        .busy(busy),
        .triggered(triggered),
        .forced(forced),
        .done(done),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: phase 0 idle, 1 waiting for trigger, 2 recording, 3 finished.
    int         m_phase;
    int         m_seen;
    int         m_rec;
    logic [7:0] m_last;
    logic       e_push;
    logic [7:0] e_in;
    logic       e_trig;
    logic       e_forced;
    logic       e_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  <= 0;
            m_seen   <= 0;
            m_rec    <= 0;
            m_last   <= 8'h00;
            e_push   <= 1'b0;
            e_in     <= 8'h00;
            e_trig   <= 1'b0;
            e_forced <= 1'b0;
            e_ovf    <= 1'b0;
        end else begin
            automatic int         ph   = m_phase;
            automatic int         seen = m_seen;
            automatic int         rec  = m_rec;
            automatic bit         push = 1'b0;
            automatic bit         trg  = 1'b0;
            automatic bit         frc  = e_forced;
            automatic bit         ovf  = e_ovf;
            automatic bit         take = 1'b0;
            automatic logic [7:0] din  = e_in;
            automatic logic [7:0] d    = bus.adc_data;
            automatic bit         lvl_hit = 1'b0;
            automatic bit         tmo_hit = 1'b0;
            if (abort) begin
                ph = 0;
            end else if (arm && (ph == 0 || ph == 3)) begin
                ph   = 1;
                seen = 0;
                frc  = 1'b0;
                ovf  = 1'b0;
            end else if (bus.adc_valid && ph == 1) begin
                seen = seen + 1;
                lvl_hit = (seen > 1) && (trig_slope ? (m_last > trig_level && d <= trig_level)
                                                    : (m_last < trig_level && d >= trig_level));
                tmo_hit = (seen > 1) && trig_auto && (seen >= TMO);
                if (lvl_hit || tmo_hit) begin
                    ph   = 2;
                    rec  = 0;
                    trg  = 1'b1;
                    frc  = !lvl_hit;
                    take = 1'b1;
                end
                m_last <= d;
            end else if (bus.adc_valid && ph == 2) begin
                take = 1'b1;
            end
            if (take) begin
                rec = rec + 1;
                if (bus.fifo_full) ovf = 1'b1;
                else begin
                    push = 1'b1;
                    din  = d;
                end
                if (rec == REC) ph = 3;
            end
            m_phase  <= ph;
            m_seen   <= seen;
            m_rec    <= rec;
            e_push   <= push;
            e_in     <= din;
            e_trig   <= trg;
            e_forced <= frc;
            e_ovf    <= ovf;
        end
    end

    int         n_cmp;
    int         n_bad;
    int         push_cnt;
    int         tr_cnt;
    logic [7:0] tr_val;
    logic [7:0] last_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("busy", busy, (m_phase == 1 || m_phase == 2));
        chk("done", done, (m_phase == 3));
        chk("triggered", triggered, e_trig);
        chk("forced", forced, e_forced);
        chk("overflow", overflow, e_ovf);
        chk("fifo_push", bus.fifo_push, e_push);
        if (e_push) chk("fifo_in", bus.fifo_in, e_in);
        if (bus.fifo_push === 1'b1) begin
            push_cnt++;
            last_val = bus.fifo_in;
        end
        if (triggered === 1'b1) begin
            tr_cnt++;
            tr_val = bus.fifo_in;
        end
    endtask

    task automatic step(input logic a, input logic ab, input logic v, input logic [7:0] d, input logic f);
        @(negedge clk);
        compare_all();
        arm           = a;
        abort         = ab;
        bus.adc_valid = v;
        bus.adc_data  = d;
        bus.fifo_full = f;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'($urandom), 1'($urandom));
    endtask

    task automatic smp(input logic [7:0] d, input logic f);
        if ($urandom_range(0, 2) == 0) idle();
        step(1'b0, 1'b0, 1'b1, d, f);
    endtask

    task automatic do_arm(input logic v, input logic [7:0] d);
        step(1'b1, 1'b0, v, d, 1'b0);
    endtask

    task automatic do_abort();
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        idle();
    endtask

    initial begin
        automatic int         p0;
        automatic int         t0;
        automatic int         k;
        automatic logic [7:0] d;
        n_cmp = 0; n_bad = 0; push_cnt = 0; tr_cnt = 0; tr_val = 8'h00; last_val = 8'h00;
        rst_n = 1'b0; arm = 1'b0; abort = 1'b0;
        trig_level = 8'h80; trig_slope = 1'b0; trig_auto = 1'b0;
        bus.adc_valid = 1'b0; bus.adc_data = 8'h00; bus.fifo_full = 1'b0;
        for (int i = 0; i < 3; i++) idle();
        chk("reset_busy", busy, 1'b0);
        chk("reset_fifo_in", bus.fifo_in, 8'h00);
        chk("reset_done", done, 1'b0);
        rst_n = 1'b1;
        idle();

        // Rising ramp through 0x80.
        p0 = push_cnt; t0 = tr_cnt;
        do_arm(1'b0, 8'h00);
        d = 8'h70; k = 0;
        while (!done && k < 1200) begin smp(d, 1'b0); d = d + 8'd1; k++; end
        idle();
        chk("t1_pushes", push_cnt - p0, REC);
        chk("t1_trig_cnt", tr_cnt - t0, 1);
        chk("t1_first", tr_val, 8'h80);
        chk("t1_last", last_val, 8'h7F);
        chk("t1_done", done, 1'b1);

        // Falling through 0x40.
        trig_level = 8'h40; trig_slope = 1'b1;
        t0 = tr_cnt;
        do_arm(1'b0, 8'h00);
        smp(8'h50, 1'b0); smp(8'h45, 1'b0); smp(8'h40, 1'b0);
        idle();
        chk("t2_trig_cnt", tr_cnt - t0, 1);
        chk("t2_trig_val", tr_val, 8'h40);
        chk("t2_forced", forced, 1'b0);
        do_abort();

        // First valid sample only seeds the comparison.
        trig_slope = 1'b0;
        t0 = tr_cnt;
        do_arm(1'b0, 8'h00);
        smp(8'h30, 1'b0); smp(8'h50, 1'b0);
        idle();
        chk("t2b_trig_cnt", tr_cnt - t0, 1);
        chk("t2b_trig_val", tr_val, 8'h50);
        do_abort();

        // Sample in the arm cycle is ignored, so 0x50 becomes the seed.
        t0 = tr_cnt;
        do_arm(1'b1, 8'h30);
        smp(8'h50, 1'b0); smp(8'h50, 1'b0);
        idle();
        chk("t2c_trig_cnt", tr_cnt - t0, 0);
        chk("t2c_busy", busy, 1'b1);
        do_abort();

        // Auto timeout.
        trig_level = 8'h80; trig_auto = 1'b1;
        t0 = tr_cnt;
        do_arm(1'b0, 8'h00);
        for (int i = 0; i < TMO - 1; i++) smp(8'h10, 1'b0);
        idle();
        chk("t3_no_trig_early", tr_cnt - t0, 0);
        smp(8'h10, 1'b0);
        idle();
        chk("t3_trig_cnt", tr_cnt - t0, 1);
        chk("t3_forced", forced, 1'b1);
        chk("t3_trig_val", tr_val, 8'h10);
        do_abort();
        trig_auto = 1'b0;
        p0 = push_cnt;
        do_arm(1'b0, 8'h00);
        for (int i = 0; i < 40; i++) smp(8'h10, 1'b0);
        idle();
        chk("t3_normal_pushes", push_cnt - p0, 0);
        chk("t3_normal_busy", busy, 1'b1);
        do_abort();

        // Backpressure on record samples 10..19.
        p0 = push_cnt;
        do_arm(1'b0, 8'h00);
        smp(8'h7F, 1'b0);
        k = 1;
        while (!done && k < 1200) begin
            smp(8'(8'h7F + k), (k >= 10 && k <= 19));
            k++;
        end
        idle();
        chk("t4_pushes", push_cnt - p0, REC - 10);
        chk("t4_overflow", overflow, 1'b1);
        chk("t4_done", done, 1'b1);

        // Abort on record sample 100.
        p0 = push_cnt;
        do_arm(1'b0, 8'h00);
        smp(8'h7F, 1'b0);
        for (int i = 1; i < 100; i++) smp(8'(8'h7F + i), 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'hE3, 1'b0);
        idle();
        chk("t5_busy", busy, 1'b0);
        chk("t5_pushes", push_cnt - p0, 99);
        for (int i = 0; i < 20; i++) smp(8'($urandom), 1'b0);
        idle();
        chk("t5_pushes_after", push_cnt - p0, 99);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        idle();
        chk("t5_arm_abort_busy", busy, 1'b0);

        // Asynchronous reset mid-capture, then a fresh record.
        do_arm(1'b0, 8'h00);
        smp(8'h7F, 1'b0);
        for (int i = 1; i < 50; i++) smp(8'(8'h7F + i), 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_push", bus.fifo_push, 1'b0);
        chk("t6_fifo_in", bus.fifo_in, 8'h00);
        chk("t6_outs", {triggered, forced, done, overflow}, 4'b0000);
        idle(); idle();
        rst_n = 1'b1;
        p0 = push_cnt;
        do_arm(1'b0, 8'h00);
        smp(8'h7F, 1'b0);
        k = 1;
        while (!done && k < 1200) begin smp(8'(8'h7F + k), 1'b0); k++; end
        idle();
        chk("t6_pushes", push_cnt - p0, REC);
        chk("t6_done", done, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            automatic int r = $urandom_range(0, 999);
            if (i % 500 == 0) begin
                trig_level = 8'($urandom);
                trig_slope = 1'($urandom);
                trig_auto  = ($urandom_range(0, 2) != 0);
            end
            step((r < 6), (r >= 997), 1'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
